// File: rtl/calc_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : calc_exec_unit
//  Description : Calculator execution back-end. Single-cycle ADD/SUB,
//                W-cycle shift-add MUL and restoring DIV, registered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_exec_unit #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [2:0]     op,
    input  logic           do_compute,
    output logic [2*W-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           err,
    output logic           neg,
    output logic [1:0]     state_dbg
);

    localparam logic [1:0] c_S_IDLE = 2'b00;
    localparam logic [1:0] c_S_ALU  = 2'b01;
    localparam logic [1:0] c_S_ITER = 2'b10;
    localparam logic [1:0] c_S_DONE = 2'b11;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;

    localparam int               c_CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(W - 1);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_shift;   // MUL: multiplier; DIV: dividend out / quotient in
    logic [W-1:0]    r_rem;
    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_result;
    logic            r_err;
    logic            r_neg;

    logic            w_start_iter;
    logic [2*W-1:0]  w_mul_acc;
    logic [W:0]      w_div_shift;
    logic            w_div_fits;
    logic [W-1:0]    w_div_diff;
    logic [W-1:0]    w_rem_next;
    logic [W-1:0]    w_quo_next;
    logic [2*W-1:0]  w_add;
    logic [2*W-1:0]  w_sub;
    logic [2*W-1:0]  w_alu_result;
    logic            w_alu_err;
    logic            w_alu_neg;

    assign w_start_iter = ((op == c_OP_MUL) || (op == c_OP_DIV)) && (B != '0);

    assign w_mul_acc = r_shift[0] ? (r_acc + r_mcand) : r_acc;

    // Remainder stays below B, so the W-bit difference is exact when it fits
    assign w_div_shift = {r_rem, r_shift[W-1]};
    assign w_div_fits  = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[W-1:0] - r_b;
    assign w_rem_next  = w_div_fits ? w_div_diff : w_div_shift[W-1:0];
    assign w_quo_next  = {r_shift[W-2:0], w_div_fits};

    assign w_add = {{(W-1){1'b0}}, ({1'b0, r_a} + {1'b0, r_b})};
    assign w_sub = {{W{1'b0}}, r_a} - {{W{1'b0}}, r_b};

    always_comb begin
        w_alu_result = '0;
        w_alu_err    = 1'b0;
        w_alu_neg    = 1'b0;
        case (r_op)
            c_OP_ADD: w_alu_result = w_add;
            c_OP_SUB: begin
                w_alu_result = w_sub;
                w_alu_neg    = (r_a < r_b);
            end
            c_OP_MUL: w_alu_result = '0;  // only reached with B == 0
            c_OP_DIV: w_alu_err    = 1'b1;  // only reached with B == 0
            default:  w_alu_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_mcand  <= '0;
            r_shift  <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (do_compute) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_mcand <= {{W{1'b0}}, A};
                        r_shift <= (op == c_OP_DIV) ? A : B;
                        r_state <= w_start_iter ? c_S_ITER : c_S_ALU;
                    end
                end
                c_S_ALU: begin
                    r_result <= w_alu_result;
                    r_err    <= w_alu_err;
                    r_neg    <= w_alu_neg;
                    r_state  <= c_S_DONE;
                end
                c_S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == c_OP_MUL) begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= {r_mcand[2*W-2:0], 1'b0};
                        r_shift <= {1'b0, r_shift[W-1:1]};
                    end else begin
                        r_rem   <= w_rem_next;
                        r_shift <= w_quo_next;
                    end
                    // Result is written on the way into DONE so it is valid with done
                    if (r_cnt == c_LAST) begin
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        r_neg    <= 1'b0;
                        r_result <= (r_op == c_OP_MUL) ? w_mul_acc
                                                       : {w_rem_next, w_quo_next};
                        r_state  <= c_S_DONE;
                    end
                end
                c_S_DONE: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    assign result    = r_result;
    assign err       = r_err;
    assign neg       = r_neg;
    assign done      = (r_state == c_S_DONE);
    assign busy      = (r_state != c_S_IDLE);
    assign state_dbg = r_state;

endmodule
`default_nettype wire
